vend_credit_fsm: RTL and testbench
==================================

# vend_credit_fsm

Parametrised successor to the two-bit vending sequence recogniser. It accepts coins of arbitrary value on a valued coin port and accumulates credit against a configurable price. On reaching the price it dispenses, then pays back change as a train of unit pulses. It also supports cancel, inactivity timeout and rejection of overflowing or mistimed coins. It sits between the coin-acceptor front end and the dispense/change actuators.

## Interface
- PRICE, 15, item price in credit units; 1 ≤ PRICE ≤ 2^CREDIT_W−1
- CREDIT_W, 6, credit register width; MAX_CREDIT = 2^CREDIT_W−1
- COIN_W, 4, coin value width
- TIMEOUT, 1000, cycles without an accepted coin in COLLECT before auto-refund; ≥1
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset (rst=0 resets immediately)
- coin_valid  input  1  coin present this cycle
- coin_val  input  COIN_W  coin value in units, sampled when coin_valid=1
- cancel  input  1  request refund of current credit
- out  output  1  dispense pulse, one cycle
- rtrn  output  1  change pulse; each high cycle = one unit returned
- rej  output  1  coin rejected (returned physically by acceptor), one-cycle pulse
- busy  output  1  high in VEND and RETURN; coins not accepted
- credit  output  CREDIT_W  current credit, or remaining change in VEND/RETURN

## Operation
- States: IDLE (credit=0), COLLECT (0<credit<PRICE), VEND, RETURN.
- IDLE/COLLECT, coin_valid=1:
  - coin_val=0: ignored, no rej.
  - credit+coin_val > MAX_CREDIT (computed CREDIT_W+1 wide): coin rejected, rej=1 next cycle, credit unchanged.
  - else credit += coin_val, timeout counter cleared.
- After an accepted coin, sum ≥ PRICE and no cancel: go to VEND with credit = sum−PRICE.
- After an accepted coin, 0 < sum < PRICE: go to or stay in COLLECT.
- cancel in COLLECT: go to RETURN with credit = current credit (including any coin accepted the same cycle). Cancel overrides vend. No out.
- cancel in IDLE with no coin: ignored. cancel together with the first coin: RETURN with credit = coin_val.
- Timeout: the counter increments every COLLECT cycle with no accepted coin. On reaching TIMEOUT, behave exactly as cancel.
- VEND (one cycle): out=1, then go to RETURN if credit>0, else to IDLE.
- RETURN: rtrn=1 each cycle and credit decrements at the end of each cycle. Leave for IDLE on the edge where credit goes 1→0.
- busy states: coin_valid=1 → rej pulse next cycle, coin ignored. cancel ignored.
- out, rtrn and busy are decoded from the registered state, so they are glitch-free. rej is a registered pulse.

## Timing
- Reset values: state IDLE, credit 0, out 0, rtrn 0, rej 0, busy 0, timeout counter 0.
- Reset mid-operation aborts immediately. Pending change is discarded.
- A coin sampled at edge E0 shows in credit after E0.
- Purchase completed at E0 with change c:
  - out high in cycle 1 (E0..E1).
  - rtrn high in cycles 2..c+1.
  - IDLE from cycle c+2.
  - With c=0, IDLE from cycle 2.
- rej is high for exactly one cycle after the sampling edge of the rejected coin.
- Back-to-back coins on consecutive cycles are all accepted (sustained one coin per cycle).
- Throughput: one purchase per 2+c cycles minimum.

## Test plan
- Reset, then coins 10, 10 (PRICE=15) → credit 10; out one cycle with credit 5; rtrn exactly 5 cycles (credit 5,4,3,2,1); IDLE, credit 0.
- Coins 5,5,5 on consecutive cycles → out one cycle, rtrn never asserted, IDLE two cycles after the third coin.
- Coin 7, idle TIMEOUT cycles → RETURN, rtrn exactly 7 cycles, out never asserted. Also verify that a coin at cycle TIMEOUT−1 restarts the count.
- Coin 10, then coin 5 with cancel in the same cycle → no out; rtrn exactly 15 cycles.
- CREDIT_W=4, PRICE=15: coin 12, then coin 8 → rej one cycle, credit stays 12. Then coin 3 → out, no rtrn. A coin inserted during out/rtrn → rej, credit unaffected.
- rst driven low during rtrn train (between clock edges) → all outputs 0 immediately; after release, credit 0 and state IDLE.

Source files
------------

// File: rtl/vend_credit_fsm_if.sv
// Coin-acceptor / actuator bundle for vend_credit_fsm.
// master: coin front end plus actuator side (drives coins, observes outputs).
// slave : the credit FSM itself.
interface vend_credit_fsm_if #(
  parameter int COIN_W   = 4,
  parameter int CREDIT_W = 6
) ();
  logic                coin_valid;
  logic [COIN_W-1:0]   coin_val;
  logic                cancel;
  logic                out;
  logic                rtrn;
  logic                rej;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output coin_valid, coin_val, cancel,
    input  out, rtrn, rej, busy, credit
  );

  modport slave (
    input  coin_valid, coin_val, cancel,
    output out, rtrn, rej, busy, credit
  );
endinterface

// File: rtl/vend_credit_fsm.sv
// Vending credit controller: accumulates valued coins against PRICE,
// dispenses, then pays change back as one rtrn pulse per unit.
// Supports cancel, inactivity timeout and rejection of overflowing or
// mistimed coins.
module vend_credit_fsm #(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 6,
  parameter int COIN_W   = 4,
  parameter int TIMEOUT  = 1000
) (
  input logic            clk,
  input logic            rst,
  vend_credit_fsm_if.slave bus
);

  localparam int SUM_W = ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [SUM_W-1:0]    MAX_SUM   = SUM_W'((1 << CREDIT_W) - 1);
  localparam logic [SUM_W-1:0]    PRICE_S   = SUM_W'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_RETURN
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                rej_q, rej_d;

  logic [SUM_W-1:0]    sum;
  logic                coin_nz;
  logic                fits;
  logic                accept;
  logic                timed_out;
  logic [CREDIT_W-1:0] credit_now;

  // Overflow test is done one bit wider than the credit register.
  assign sum     = SUM_W'(credit_q) + SUM_W'(bus.coin_val);
  assign coin_nz = bus.coin_valid && (bus.coin_val != '0);
  assign fits    = (sum <= MAX_SUM);

  // State, credit, timeout counter and rej pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      tmo_q    <= '0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      rej_q    <= rej_d;
    end
  end

  // Next-state, next-credit and coin accept/reject decisions.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    tmo_d      = '0;
    rej_d      = 1'b0;
    accept     = 1'b0;
    timed_out  = 1'b0;
    credit_now = credit_q;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        accept     = coin_nz && fits;
        rej_d      = coin_nz && !fits;
        credit_now = accept ? sum[CREDIT_W-1:0] : credit_q;
        timed_out  = (state_q == S_COLLECT) && !accept && (tmo_q == TMO_LAST);
        if (!accept && (state_q == S_COLLECT))
          tmo_d = tmo_q + TMO_W'(1);

        // Cancel (or timeout) wins over vend; with zero credit it is a no-op,
        // which covers cancel in IDLE without an accepted coin.
        if ((bus.cancel || timed_out) && (credit_now != '0)) begin
          state_d  = S_RETURN;
          credit_d = credit_now;
          tmo_d    = '0;
        end else if (accept && (sum >= PRICE_S)) begin
          state_d  = S_VEND;
          credit_d = sum[CREDIT_W-1:0] - PRICE_C;
          tmo_d    = '0;
        end else if (accept) begin
          state_d  = S_COLLECT;
          credit_d = sum[CREDIT_W-1:0];
        end
      end

      S_VEND: begin
        rej_d   = bus.coin_valid;
        state_d = (credit_q != '0) ? S_RETURN : S_IDLE;
      end

      S_RETURN: begin
        rej_d    = bus.coin_valid;
        credit_d = credit_q - CREDIT_W'(1);
        if (credit_q == CREDIT_W'(1))
          state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  assign bus.out    = (state_q == S_VEND);
  assign bus.rtrn   = (state_q == S_RETURN);
  assign bus.busy   = (state_q == S_VEND) || (state_q == S_RETURN);
  assign bus.rej    = rej_q;
  assign bus.credit = credit_q;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Bench for vend_credit_fsm: two instances (wide and narrow credit register)
// share one stimulus stream; each is compared every cycle against a
// transaction-level model that schedules the dispense/change pulse train
// as a queue of expected output cycles.
module tb_vend_credit_fsm;

  localparam int PRICE  = 15;
  localparam int COIN_W = 4;
  localparam int CW_A   = 6;
  localparam int CW_B   = 4;
  localparam int TMO_A  = 1000;
  localparam int TMO_B  = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;

  vend_credit_fsm_if #(.COIN_W(COIN_W), .CREDIT_W(CW_A)) ifa ();
  vend_credit_fsm_if #(.COIN_W(COIN_W), .CREDIT_W(CW_B)) ifb ();

  vend_credit_fsm #(.PRICE(PRICE), .CREDIT_W(CW_A), .COIN_W(COIN_W), .TIMEOUT(TMO_A))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  vend_credit_fsm #(.PRICE(PRICE), .CREDIT_W(CW_B), .COIN_W(COIN_W), .TIMEOUT(TMO_B))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_out_a, n_rtrn_a;

  // One scheduled busy cycle: dispense or change pulse, and the credit shown.
  typedef struct {
    bit o;
    bit r;
    int cr;
  } ent_t;

  ent_t q_a[$];
  ent_t q_b[$];
  int   mcr[2];
  int   mtm[2];
  bit   mrj[2];

  function automatic int maxc(int k);
    return (k == 0) ? (1 << CW_A) - 1 : (1 << CW_B) - 1;
  endfunction

  function automatic int tmo(int k);
    return (k == 0) ? TMO_A : TMO_B;
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic void qpush(int k, bit o, bit r, int cr);
    ent_t e;
    e.o = o; e.r = r; e.cr = cr;
    if (k == 0) q_a.push_back(e); else q_b.push_back(e);
  endfunction

  function automatic ent_t qfront(int k);
    return (k == 0) ? q_a[0] : q_b[0];
  endfunction

  function automatic void qpop(int k);
    if (k == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
  endfunction

  function automatic void m_reset();
    q_a.delete();
    q_b.delete();
    for (int k = 0; k < 2; k++) begin
      mcr[k] = 0; mtm[k] = 0; mrj[k] = 1'b0;
    end
  endfunction

  // Dispense (optional) followed by c unit pulses counting down.
  function automatic void schedule(int k, bit with_out, int c);
    if (with_out) qpush(k, 1'b1, 1'b0, c);
    for (int n = c; n > 0; n--) qpush(k, 1'b0, 1'b1, n);
    mcr[k] = 0;
    mtm[k] = 0;
  endfunction

  // Advance model k across one clock edge given the inputs of that cycle.
  function automatic void m_step(int k, bit v, int val, bit c);
    bit acc;
    mrj[k] = 1'b0;
    if (qsize(k) > 0) begin
      mrj[k] = v;
      qpop(k);
    end else begin
      acc = 1'b0;
      if (v && val != 0) begin
        if (mcr[k] + val > maxc(k)) mrj[k] = 1'b1;
        else begin
          acc = 1'b1;
          mcr[k] += val;
          mtm[k] = 0;
        end
      end
      if (acc) begin
        if (c) schedule(k, 1'b0, mcr[k]);
        else if (mcr[k] >= PRICE) schedule(k, 1'b1, mcr[k] - PRICE);
      end else if (mcr[k] > 0) begin
        mtm[k]++;
        if (c || mtm[k] == tmo(k)) schedule(k, 1'b0, mcr[k]);
      end
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ph);
    logic o, r, j, b;
    logic [31:0] cr;
    ent_t e;
    string n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        o = ifa.out; r = ifa.rtrn; j = ifa.rej; b = ifa.busy; cr = 32'(ifa.credit);
      end else begin
        o = ifb.out; r = ifb.rtrn; j = ifb.rej; b = ifb.busy; cr = 32'(ifb.credit);
      end
      n = $sformatf("%s.%s", ph, (k == 0) ? "A" : "B");
      if (qsize(k) > 0) begin
        e = qfront(k);
        chk({n, ".out"}, 32'(o), 32'(e.o));
        chk({n, ".rtrn"}, 32'(r), 32'(e.r));
        chk({n, ".busy"}, 32'(b), 1);
        chk({n, ".credit"}, cr, e.cr);
      end else begin
        chk({n, ".out"}, 32'(o), 0);
        chk({n, ".rtrn"}, 32'(r), 0);
        chk({n, ".busy"}, 32'(b), 0);
        chk({n, ".credit"}, cr, mcr[k]);
      end
      chk({n, ".rej"}, 32'(j), 32'(mrj[k]));
    end
  endtask

  task automatic cyc(bit v, int val, bit c, string ph);
    ifa.coin_valid = v; ifa.coin_val = COIN_W'(val); ifa.cancel = c;
    ifb.coin_valid = v; ifb.coin_val = COIN_W'(val); ifb.cancel = c;
    @(posedge clk);
    m_step(0, v, val, c);
    m_step(1, v, val, c);
    #1;
    if (ifa.out)  n_out_a++;
    if (ifa.rtrn) n_rtrn_a++;
    check_all(ph);
  endtask

  task automatic wait_idle_a(string ph, int limit);
    for (int i = 0; i < limit; i++) begin
      if (!ifa.busy) break;
      cyc(1'b0, 0, 1'b0, ph);
    end
    chk({ph, ".idle_bound"}, 32'(ifa.busy), 0);
  endtask

  // Return both instances to IDLE with zero credit; cancel is harmless
  // while busy and refunds any partial credit.
  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (!ifa.busy && !ifb.busy && ifa.credit == '0 && ifb.credit == '0) break;
      cyc(1'b0, 0, 1'b1, "drain");
    end
    chk("drain.bound", 32'({ifa.busy, ifb.busy}), 0);
    cyc(1'b0, 0, 1'b0, "drain");
  endtask

  task automatic chk_all_zero(string ph);
    chk({ph, ".A.out"}, 32'(ifa.out), 0);
    chk({ph, ".A.rtrn"}, 32'(ifa.rtrn), 0);
    chk({ph, ".A.rej"}, 32'(ifa.rej), 0);
    chk({ph, ".A.busy"}, 32'(ifa.busy), 0);
    chk({ph, ".A.credit"}, 32'(ifa.credit), 0);
    chk({ph, ".B.out"}, 32'(ifb.out), 0);
    chk({ph, ".B.rtrn"}, 32'(ifb.rtrn), 0);
    chk({ph, ".B.rej"}, 32'(ifb.rej), 0);
    chk({ph, ".B.busy"}, 32'(ifb.busy), 0);
    chk({ph, ".B.credit"}, 32'(ifb.credit), 0);
  endtask

  initial begin
    int w;
    bit dense, v, c;
    int val;

    ifa.coin_valid = 1'b0; ifa.coin_val = '0; ifa.cancel = 1'b0;
    ifb.coin_valid = 1'b0; ifb.coin_val = '0; ifb.cancel = 1'b0;
    m_reset();
    #22;
    chk_all_zero("reset");
    rst = 1'b1;

    // Two 10-coins: dispense with 5 change.
    n_out_a = 0; n_rtrn_a = 0;
    cyc(1'b1, 10, 1'b0, "t1");
    chk("t1.credit10", 32'(ifa.credit), 10);
    cyc(1'b1, 10, 1'b0, "t1");
    chk("t1.out", 32'(ifa.out), 1);
    chk("t1.change", 32'(ifa.credit), 5);
    wait_idle_a("t1", 50);
    chk("t1.n_out", n_out_a, 1);
    chk("t1.n_rtrn", n_rtrn_a, 5);
    chk("t1.final_credit", 32'(ifa.credit), 0);
    drain();

    // Exact price on back-to-back coins: no change.
    n_out_a = 0; n_rtrn_a = 0;
    cyc(1'b1, 5, 1'b0, "t2");
    cyc(1'b1, 5, 1'b0, "t2");
    cyc(1'b1, 5, 1'b0, "t2");
    chk("t2.out", 32'(ifa.out), 1);
    cyc(1'b0, 0, 1'b0, "t2");
    chk("t2.idle", 32'(ifa.busy), 0);
    chk("t2.n_rtrn", n_rtrn_a, 0);
    chk("t2.n_out", n_out_a, 1);
    drain();

    // Inactivity timeout refunds the credit.
    n_out_a = 0; n_rtrn_a = 0;
    cyc(1'b1, 7, 1'b0, "t3");
    w = 0;
    while (!ifa.busy && w < TMO_A + 5) begin
      cyc(1'b0, 0, 1'b0, "t3");
      w++;
    end
    chk("t3.tmo_cycles", w, TMO_A);
    wait_idle_a("t3", 50);
    chk("t3.n_rtrn", n_rtrn_a, 7);
    chk("t3.n_out", n_out_a, 0);
    drain();

    // A coin one cycle before timeout restarts the count.
    cyc(1'b1, 7, 1'b0, "t3b");
    repeat (TMO_A - 2) cyc(1'b0, 0, 1'b0, "t3b");
    cyc(1'b1, 3, 1'b0, "t3b");
    chk("t3b.credit", 32'(ifa.credit), 10);
    repeat (TMO_A - 1) cyc(1'b0, 0, 1'b0, "t3b");
    chk("t3b.not_yet", 32'(ifa.busy), 0);
    cyc(1'b0, 0, 1'b0, "t3b");
    chk("t3b.rtrn", 32'(ifa.rtrn), 1);
    chk("t3b.refund", 32'(ifa.credit), 10);
    drain();

    // Cancel with a same-cycle coin: full refund, no dispense.
    n_out_a = 0; n_rtrn_a = 0;
    cyc(1'b1, 10, 1'b0, "t4");
    cyc(1'b1, 5, 1'b1, "t4");
    wait_idle_a("t4", 50);
    chk("t4.n_out", n_out_a, 0);
    chk("t4.n_rtrn", n_rtrn_a, 15);
    drain();

    // Overflow rejection on the narrow instance; busy-time coins rejected.
    cyc(1'b1, 12, 1'b0, "t5");
    cyc(1'b1, 8, 1'b0, "t5");
    chk("t5.b_rej", 32'(ifb.rej), 1);
    chk("t5.b_credit", 32'(ifb.credit), 12);
    cyc(1'b0, 0, 1'b0, "t5");
    chk("t5.b_rej_once", 32'(ifb.rej), 0);
    cyc(1'b1, 3, 1'b0, "t5");
    chk("t5.b_out", 32'(ifb.out), 1);
    chk("t5.b_change", 32'(ifb.credit), 0);
    chk("t5.a_rej_busy", 32'(ifa.rej), 1);
    chk("t5.a_credit", 32'(ifa.credit), 4);
    cyc(1'b1, 4, 1'b0, "t5");
    chk("t5.b_rej_vend", 32'(ifb.rej), 1);
    chk("t5.b_credit_after", 32'(ifb.credit), 0);
    drain();

    // Asynchronous reset in the middle of the change train.
    cyc(1'b1, 10, 1'b0, "t6");
    cyc(1'b1, 10, 1'b0, "t6");
    cyc(1'b0, 0, 1'b0, "t6");
    cyc(1'b0, 0, 1'b0, "t6");
    chk("t6.in_rtrn", 32'(ifa.rtrn), 1);
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("t6.async");
    m_reset();
    #2;
    rst = 1'b1;
    cyc(1'b0, 0, 1'b0, "t6");
    chk("t6.post_credit", 32'(ifa.credit), 0);
    chk("t6.post_busy", 32'(ifa.busy), 0);

    // Randomised traffic, alternating dense and sparse coin phases.
    for (int blk = 0; blk < 15; blk++) begin
      dense = ($urandom_range(0, 1) == 1);
      repeat (200) begin
        v   = dense ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 39) == 0);
        val = $urandom_range(0, 15);
        c   = ($urandom_range(0, 39) == 0);
        cyc(v, val, c, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
